fdiv_wb_queue: RTL and testbench
================================

# fdiv_wb_queue

Writeback queue and issue-credit controller directly downstream of the pipelined `fdiv` unit. It captures every tagged quotient leaving `fdiv` (`flagout`/`addout`/`y`) into a FIFO and presents results to the shared register-file write port with a valid/ready handshake. It also tracks outstanding destination registers so the issue stage never overflows the queue and never issues a WAW hazard. `fdiv` itself cannot stall, so the credit check here is the only back-pressure mechanism.

## Interface
- `DEPTH`, 8: FIFO entries and maximum in-flight divides (power of two, ≥ `NSTAGE`+1).
- `NSTAGE`, 4: `fdiv` latency in cycles, issue to `flagout`; used only for the in-flight check in verification.
- `clk` in 1: single clock, all state on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `iss_en` in 1: issue stage launches a divide this cycle; honoured only when `iss_ok`=1.
- `iss_rd` in 5: destination register of the launched divide.
- `iss_ok` out 1: combinational; 1 when `cnt` < `DEPTH` and `pend[iss_rd]`=0.
- `in_flag` in 1: `fdiv` `flagout`; 1 = valid result this cycle.
- `in_addr` in 5: `fdiv` `addout`, destination register.
- `in_data` in 32: `fdiv` `y`, IEEE-754 single result.
- `wb_valid` out 1: head entry available.
- `wb_addr` out 5: head destination register.
- `wb_data` out 32: head result.
- `wb_ready` in 1: write port accepts head this cycle.
- `pend` out 32: bit r = a divide targeting register r is issued and not yet written back.
- `cnt` out $clog2(DEPTH)+1: in-flight count, issued minus written back.
- `err` out 1: sticky protocol-error flag.

## Operation
- Issue accept: `iss_en`=1 and `iss_ok`=1 → set `pend[iss_rd]`; `cnt` +1.
- Illegal issue: `iss_en`=1 and `iss_ok`=0 → no state change except `err`←1.
- Push: `in_flag`=1 → write {`in_addr`,`in_data`} at tail; tail pointer +1 mod `DEPTH`.
- Pop: `wb_valid`=1 and `wb_ready`=1 → head pointer +1 mod `DEPTH`; clear `pend[wb_addr]`; `cnt` −1.
- FIFO is first-word-fall-through. `wb_valid` = occupancy ≠ 0. `wb_addr`/`wb_data` are driven from the head entry.
- Occupancy counter: separate from `cnt`, width $clog2(DEPTH)+1. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Push while occupancy = `DEPTH` with no simultaneous pop: entry dropped, `err`←1. Unreachable when the credit rule is obeyed.
- Push with `in_flag`=1 and `pend[in_addr]`=0: entry still queued, `err`←1.
- Simultaneous issue and pop: `cnt` unchanged. Both `pend` updates apply, set for `iss_rd` and clear for `wb_addr`. Equal addresses cannot occur because `pend[iss_rd]` is already 1 and issue is refused.
- Simultaneous push and pop at occupancy = `DEPTH`: legal; occupancy unchanged.
- `err` clears only on reset.

## Timing
- Reset (`rstn`=0 at a rising edge): `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `pend`=0, `cnt`=0, `err`=0, pointers and occupancy 0. FIFO contents are not cleared. Reset mid-operation discards all queued and in-flight state. Results that `fdiv` emits after reset are pushed normally and flag `err`.
- Push to `wb_valid` latency: 1 cycle. An entry pushed at edge t is visible after edge t, with no same-cycle bypass.
- Pop: head advances at the accepting edge. The next entry, if any, is presented in the following cycle, so back-to-back pops run at 1/cycle.
- `pend`/`cnt`: registered; the update is visible the cycle after the issue or pop edge. `iss_ok` reacts combinationally to `iss_rd` within the same cycle.
- Ordering: writeback order equals `fdiv` output order, which equals issue order.

## Test plan
- Reset: drive `rstn`=0 for 2 cycles with `in_flag`=1 → all outputs 0, `iss_ok`=1 for any `iss_rd`.
- Single op: issue rd=5, then push `in_addr`=5 with `in_data`=0x3F000000 four cycles later, `wb_ready`=1 → `wb_valid`=1 for exactly 1 cycle with `wb_addr`=5 and `wb_data`=0x3F000000. `pend[5]` goes 1 then 0. `cnt` goes 0→1→0.
- Credit: issue 8 distinct rd with `wb_ready`=0 → `iss_ok`=0 at `cnt`=8. Issue 9 is refused and sets `err`=1. All 8 results queue, then drain in issue order at 1/cycle once `wb_ready`=1.
- WAW: issue rd=3, then try rd=3 again → `iss_ok`=0 until the cycle after the rd=3 pop. An issue to rd=4 in the same window is accepted.
- Wrap and simultaneous events: stream 20 ops with `wb_ready` toggling 1,0,1 against a back-to-back push/pop at full occupancy → no loss, order preserved, `err`=0.
- Mid-run reset: reset with 3 entries queued → `wb_valid`=0 next cycle; a subsequent `in_flag` push with `pend`=0 sets `err`=1.

Source files
------------

// File: rtl/fdiv_wb_queue.sv
// Writeback FIFO and issue-credit tracker behind the pipelined fdiv unit.
// Buffers tagged quotients for the register-file write port and keeps issue from overflowing the queue or creating WAW hazards.
module fdiv_wb_queue #(
    parameter int DEPTH  = 8,
    parameter int NSTAGE = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     iss_en,
    input  logic [4:0]               iss_rd,
    output logic                     iss_ok,
    input  logic                     in_flag,
    input  logic [4:0]               in_addr,
    input  logic [31:0]              in_data,
    output logic                     wb_valid,
    output logic [4:0]               wb_addr,
    output logic [31:0]              wb_data,
    input  logic                     wb_ready,
    output logic [31:0]              pend,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // The credit scheme only guarantees no overflow if every in-flight divide has a slot.
    if (DEPTH < NSTAGE + 1) begin : g_depth_check
        $error("fdiv_wb_queue: DEPTH must be at least NSTAGE+1");
    end

    logic [36:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_q, pend_d;
    logic          err_q, err_d;

    logic issAccept;
    logic doPop;
    logic doPush;
    logic cntDec;

    assign wb_valid  = (occ_q != '0);
    assign wb_addr   = wb_valid ? mem_q[head_q][36:32] : 5'd0;
    assign wb_data   = wb_valid ? mem_q[head_q][31:0]  : 32'd0;
    assign iss_ok    = (cnt_q < FULL) && !pend_q[iss_rd];
    assign issAccept = iss_en && iss_ok;
    assign doPop     = wb_valid && wb_ready;
    assign doPush    = in_flag && ((occ_q != FULL) || doPop);
    // Stray results after a reset can be popped with nothing outstanding; keep cnt from wrapping.
    assign cntDec    = doPop && (cnt_q != '0);

    assign pend = pend_q;
    assign cnt  = cnt_q;
    assign err  = err_q;

    always_comb begin
        pend_d = pend_q;
        if (doPop) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (issAccept) begin
            pend_d[iss_rd] = 1'b1;
        end

        cnt_d = cnt_q;
        case ({issAccept, cntDec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        occ_d = occ_q;
        case ({doPush, doPop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        head_d = head_q + AW'(doPop);
        tail_d = tail_q + AW'(doPush);

        err_d = err_q
              | (iss_en && !iss_ok)
              | (in_flag && !doPush)
              | (in_flag && !pend_q[in_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[tail_q] <= {in_addr, in_data};
        end
    end

endmodule

// File: tb/tb_fdiv_wb_queue.sv
// Self-checking bench for fdiv_wb_queue: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fdiv_wb_queue;

    localparam int DEPTH  = 8;
    localparam int NSTAGE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        iss_ok;
    logic        in_flag;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic [31:0] pend;
    logic [3:0]  cnt;
    logic        err;

    always #5 clk = ~clk;

    fdiv_wb_queue #(.DEPTH(DEPTH), .NSTAGE(NSTAGE)) dut (
        .clk(clk), .rstn(rstn),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_ok(iss_ok),
        .in_flag(in_flag), .in_addr(in_addr), .in_data(in_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .pend(pend), .cnt(cnt), .err(err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } slotT;

    // Emulated fdiv pipeline: an accepted issue re-emerges NSTAGE calls later as a push.
    slotT        fdivPipe[$];
    int          opIndex = 0;

    // Reference model: results waiting for writeback, outstanding registers, credit count.
    logic [36:0] modelQ[$];
    logic [31:0] modelPend = '0;
    int          modelCnt  = 0;
    logic        modelErr  = 1'b0;
    bit          modelValid = 1'b0;

    function automatic logic modelIssOk(input logic [4:0] rd);
        return (modelCnt < DEPTH) && !modelPend[rd];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic modelStep();
        logic       doPop, doIss, doPush;
        logic [4:0] popAddr;
        if (!rstn) begin
            modelQ.delete();
            modelPend  = '0;
            modelCnt   = 0;
            modelErr   = 1'b0;
            modelValid = 1'b1;
            return;
        end
        doPop  = (modelQ.size() != 0) && wb_ready;
        doIss  = iss_en && modelIssOk(iss_rd);
        doPush = in_flag && ((modelQ.size() < DEPTH) || doPop);
        if (iss_en && !doIss)             modelErr = 1'b1;
        if (in_flag && !doPush)           modelErr = 1'b1;
        if (in_flag && !modelPend[in_addr]) modelErr = 1'b1;
        if (doPop) begin
            popAddr = modelQ[0][36:32];
            void'(modelQ.pop_front());
            modelPend[popAddr] = 1'b0;
            if (modelCnt > 0) modelCnt--;
        end
        if (doIss) begin
            modelPend[iss_rd] = 1'b1;
            modelCnt++;
        end
        if (doPush) modelQ.push_back({in_addr, in_data});
    endtask

    // Drive one cycle of inputs, let the edge happen, then update the model.
    task automatic applyStimulus(input logic rstnVal, input logic issEn, input logic [4:0] issRd,
                                 input logic wbReady, input logic frc,
                                 input logic [4:0] fAddr, input logic [31:0] fData);
        slotT head, nw;
        head = fdivPipe.pop_front();
        nw   = '0;
        if (rstnVal && issEn && modelIssOk(issRd)) begin
            nw.v = 1'b1;
            nw.a = issRd;
            nw.d = 32'h3F00_0000 + 32'(opIndex << 12);
            opIndex++;
        end
        fdivPipe.push_back(nw);
        rstn     = rstnVal;
        iss_en   = issEn;
        iss_rd   = issRd;
        wb_ready = wbReady;
        if (frc) begin
            in_flag = 1'b1;
            in_addr = fAddr;
            in_data = fData;
        end else begin
            in_flag = head.v;
            in_addr = head.a;
            in_data = head.d;
        end
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input logic wbReady);
        applyStimulus(1'b1, 1'b0, 5'd0, wbReady, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic issue(input logic [4:0] rd, input logic wbReady);
        applyStimulus(1'b1, 1'b1, rd, wbReady, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic probeIssOk(input string name, input logic [4:0] rd, input logic expected);
        iss_rd = rd;
        #1;
        checkOutput(name, 64'(iss_ok), 64'(expected));
    endtask

    // Every cycle after the first reset, the DUT outputs must match the model.
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid) begin
                checkOutput("cyc_wb_valid", 64'(wb_valid), 64'(modelQ.size() != 0));
                checkOutput("cyc_wb_addr", 64'(wb_addr), (modelQ.size() != 0) ? 64'(modelQ[0][36:32]) : 64'd0);
                checkOutput("cyc_wb_data", 64'(wb_data), (modelQ.size() != 0) ? 64'(modelQ[0][31:0]) : 64'd0);
                checkOutput("cyc_pend", 64'(pend), 64'(modelPend));
                checkOutput("cyc_cnt", 64'(cnt), 64'(modelCnt));
                checkOutput("cyc_err", 64'(err), 64'(modelErr));
                checkOutput("cyc_iss_ok", 64'(iss_ok), 64'(modelIssOk(iss_rd)));
            end
        end
    end

    initial begin
        int issued;
        int popCount;
        logic wr;
        logic en;

        rstn = 1'b0; iss_en = 1'b0; iss_rd = '0; wb_ready = 1'b0;
        in_flag = 1'b0; in_addr = '0; in_data = '0;
        for (int i = 0; i < NSTAGE; i++) fdivPipe.push_back('0);

        // Reset held two cycles while fdiv claims a valid result.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_0001);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 32'hDEAD_0001);
        checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
        checkOutput("rst_wb_addr", 64'(wb_addr), 64'd0);
        checkOutput("rst_wb_data", 64'(wb_data), 64'd0);
        checkOutput("rst_pend", 64'(pend), 64'd0);
        checkOutput("rst_cnt", 64'(cnt), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        probeIssOk("rst_iss_ok_r0", 5'd0, 1'b1);
        probeIssOk("rst_iss_ok_r5", 5'd5, 1'b1);
        probeIssOk("rst_iss_ok_r31", 5'd31, 1'b1);

        // Single divide to r5, result arrives NSTAGE cycles later.
        issue(5'd5, 1'b1);
        checkOutput("single_pend_set", 64'(pend), 64'h20);
        checkOutput("single_cnt_1", 64'(cnt), 64'd1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        checkOutput("single_not_yet", 64'(wb_valid), 64'd0);
        idle(1'b1);
        checkOutput("single_wb_valid", 64'(wb_valid), 64'd1);
        checkOutput("single_wb_addr", 64'(wb_addr), 64'd5);
        checkOutput("single_wb_data", 64'(wb_data), 64'h3F00_0000);
        idle(1'b1);
        checkOutput("single_wb_done", 64'(wb_valid), 64'd0);
        checkOutput("single_pend_clr", 64'(pend), 64'd0);
        checkOutput("single_cnt_0", 64'(cnt), 64'd0);

        // Credit exhaustion: eight distinct targets with the write port stalled.
        for (int i = 0; i < 8; i++) issue(5'(10 + i), 1'b0);
        checkOutput("credit_cnt_8", 64'(cnt), 64'd8);
        probeIssOk("credit_iss_ok_0", 5'd20, 1'b0);
        issue(5'd20, 1'b0);
        checkOutput("credit_err", 64'(err), 64'd1);
        checkOutput("credit_cnt_hold", 64'(cnt), 64'd8);
        idle(1'b0); idle(1'b0); idle(1'b0);
        checkOutput("credit_full_valid", 64'(wb_valid), 64'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("credit_drain_addr", 64'(wb_addr), 64'(10 + i));
            checkOutput("credit_drain_data", 64'(wb_data), 64'(32'h3F00_0000 + 32'((1 + i) << 12)));
            idle(1'b1);
        end
        checkOutput("credit_empty", 64'(wb_valid), 64'd0);
        checkOutput("credit_pend_0", 64'(pend), 64'd0);
        resetCycle();

        // WAW: second issue to r3 is held off until the r3 result has been written back.
        issue(5'd3, 1'b1);
        probeIssOk("waw_block_early", 5'd3, 1'b0);
        issue(5'd4, 1'b1);
        checkOutput("waw_pend_3_4", 64'(pend), 64'h18);
        issue(5'd3, 1'b1);
        checkOutput("waw_err", 64'(err), 64'd1);
        idle(1'b1); idle(1'b1);
        probeIssOk("waw_block_pushed", 5'd3, 1'b0);
        idle(1'b1);
        probeIssOk("waw_release", 5'd3, 1'b1);
        checkOutput("waw_pend_4", 64'(pend), 64'h10);
        idle(1'b1);
        checkOutput("waw_pend_0", 64'(pend), 64'd0);
        resetCycle();

        // Streaming with pointer wrap: fill, then drain with wb_ready cycling 1,0,1.
        issued   = 0;
        popCount = 0;
        for (int cyc = 0; cyc < 200 && popCount < 20; cyc++) begin
            wr = (cyc < 12) ? 1'b0 : (((cyc - 12) % 3) != 1);
            en = (issued < 20) && modelIssOk(5'(issued));
            if (wb_valid && wr) begin
                checkOutput("wrap_order", 64'(wb_addr), 64'(popCount));
                popCount++;
            end
            applyStimulus(1'b1, en, 5'(issued), wr, 1'b0, 5'd0, 32'd0);
            if (en) issued++;
        end
        checkOutput("wrap_pop_count", 64'(popCount), 64'd20);
        checkOutput("wrap_err", 64'(err), 64'd0);
        checkOutput("wrap_cnt", 64'(cnt), 64'd0);

        // Reset with three results queued, then a stray result arrives.
        issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0);
        idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b0);
        checkOutput("mid_cnt_3", 64'(cnt), 64'd3);
        checkOutput("mid_valid", 64'(wb_valid), 64'd1);
        resetCycle();
        checkOutput("mid_rst_valid", 64'(wb_valid), 64'd0);
        checkOutput("mid_rst_cnt", 64'(cnt), 64'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 32'h4040_0000);
        checkOutput("mid_stray_err", 64'(err), 64'd1);
        checkOutput("mid_stray_addr", 64'(wb_addr), 64'd9);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
